ascon_phase_ctrl: RTL
=====================

Name: ascon_phase_ctrl

Overview:
- Parametrised control FSM for the full ASCON-128 encryption flow: initialisation, associated data (AD), plaintext (PT), finalisation and tag.
- Successor to the init-only controller. It adds an internal round counter, configurable round counts, runtime AD/PT block counts and a valid/ready block handshake.
- Drives the state-register datapath (permutation, key/data/domain XORs).
- Sits between the top-level interface and the ASCON datapath.

Parameters:
- ROUNDS_A, 12, rounds for init/final permutation p^a (2..12).
- ROUNDS_B, 6, rounds for data-block permutation p^b (2..12).
- MAX_BLOCKS, 15, max blocks per phase. BLK_W = $clog2(MAX_BLOCKS+1).

Ports:
- clock_i  in  1  single clock.
- reset_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start request, honoured only in IDLE.
- nb_ad_i  in  BLK_W  AD block count, sampled on accepted start.
- nb_pt_i  in  BLK_W  PT block count, sampled on accepted start. 0 is treated as 1.
- blk_valid_i  in  1  datapath holds a valid data block.
- blk_ready_o  out  1  block consumed this cycle.
- round_o  out  4  round-constant index to the permutation.
- en_reg_state_o  out  1  state register load.
- input_mode_o  out  1  0 = load IV||K||N, 1 = feedback.
- xor_data_begin_o  out  1  XOR data block into permutation input.
- xor_key_begin_o  out  1  XOR 0^*||K into permutation input.
- xor_key_end_o  out  1  XOR 0^*||K into permutation output.
- xor_domain_o  out  1  XOR 1 into LSB of permutation output.
- cipher_valid_o  out  1  ciphertext block valid.
- tag_valid_o  out  1  tag valid.
- end_o  out  1  operation complete.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset: async; state = IDLE, rc = 0, counters = 0. All outputs 0 immediately. Reset mid-operation aborts with no pending effects.
- Round counter: rc counts 0..N-1, with N = ROUNDS_A or ROUNDS_B. round_o = 12 - N + rc (e.g. p^6 gives 6..11).
- rc clears on phase entry. A "last" flag is asserted when rc == N-1.
- en_reg_state_o = 1 on every permutation round cycle, 0 otherwise.
- States: IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FIN_PERM, TAG.
- IDLE:
  - All outputs 0.
  - start_i = 1: latch nb_ad_i and nb_pt_i into ad_cnt/pt_cnt, go to INIT.
- INIT (ROUNDS_A cycles):
  - rc = 0: input_mode_o = 0. Otherwise input_mode_o = 1.
  - Last cycle: xor_key_end_o = 1. If ad_cnt == 0, also xor_domain_o = 1.
  - Next: AD_WAIT if ad_cnt > 0, else PT_WAIT.
- WAIT states (AD/PT): the handshake cycle is round 0 of the following permutation.
  - blk_ready_o = blk_valid_i.
  - blk_valid_i = 0: en_reg_state_o = 0, rc holds, all XOR flags 0 (stall, any length).
  - blk_valid_i = 1: round 0 executes with en_reg_state_o = 1, input_mode_o = 1, xor_data_begin_o = 1, rc -> 1.
  - PT_WAIT handshake additionally asserts cipher_valid_o.
  - PT_WAIT when pt_cnt == 1 (last block) uses ROUNDS_A, asserts xor_key_begin_o, and goes to FIN_PERM.
  - All other handshakes use ROUNDS_B and go to AD_PERM / PT_PERM.
- AD_PERM:
  - Rounds 1..ROUNDS_B-1, input_mode_o = 1.
  - Last cycle: ad_cnt decrements.
  - If this was the last AD block: xor_domain_o = 1, next PT_WAIT. Otherwise next AD_WAIT.
- PT_PERM:
  - Rounds 1..ROUNDS_B-1.
  - Last cycle: pt_cnt decrements, next PT_WAIT.
- FIN_PERM:
  - Rounds 1..ROUNDS_A-1.
  - Last cycle: xor_key_end_o = 1, next TAG.
- TAG:
  - One cycle: tag_valid_o = 1, end_o = 1, busy_o = 1. Next IDLE.
- Ignored inputs:
  - start_i outside IDLE is ignored.
  - nb_*_i changes after start are ignored.
  - blk_valid_i outside WAIT states is ignored.

Decomposition:
- Package ascon_ctrl_pkg holds:
  - state_t enum;
  - ROUND_MAX = 12;
  - INPUT_MODE_LOAD = 0 and INPUT_MODE_FEEDBACK = 1.
- One sub-module, cpt_round_param:
  - 4-bit counter with clear, enable and programmable length N;
  - outputs rc and last.

Test Plan:
1. nb_ad = 0, nb_pt = 1, valid always high, start at t:
   - INIT t+1..t+12, with round_o 0..11;
   - xor_key_end_o and xor_domain_o at t+12;
   - handshake plus cipher_valid_o and xor_key_begin_o at t+13;
   - xor_key_end_o at t+24;
   - tag_valid_o and end_o at t+25;
   - IDLE at t+26.
2. nb_ad = 2, nb_pt = 2, valid high:
   - AD blocks at t+13..18 and t+19..24, round_o 6..11 each;
   - xor_domain_o at t+24;
   - PT1 at t+25..30 with cipher_valid_o at t+25;
   - final at t+31..42;
   - TAG at t+43.
3. Stall: blk_valid_i low for 3 cycles in AD_WAIT, then high:
   - during stall: blk_ready_o = 0, en_reg_state_o = 0, round_o frozen;
   - AD round 0 executes on the cycle valid rises.
4. reset_i pulsed at INIT round 5:
   - all outputs 0 in the same cycle;
   - IDLE thereafter;
   - a fresh start then gives scenario-1 timing.
5. start_i re-pulsed and nb_ad_i changed during AD_PERM:
   - no effect, original block count completes.
6. ROUNDS_A = 8, ROUNDS_B = 4, nb_ad = 1, nb_pt = 1:
   - round_o 4..11 in INIT, 8..11 in AD;
   - tag_valid_o at t+21.

Source files
------------

// File: rtl/ascon_ctrl_pkg.sv
// ascon_ctrl_pkg
//   Shared types and constants for the ASCON-128 phase controller.
//   - state_t             : controller FSM states
//   - ROUND_MAX           : number of rounds in the full permutation (12)
//   - INPUT_MODE_*        : state-register input selection
//   - round_idx()         : round-constant index for a p^N permutation
package ascon_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_AD_WAIT  = 3'd2,
    ST_AD_PERM  = 3'd3,
    ST_PT_WAIT  = 3'd4,
    ST_PT_PERM  = 3'd5,
    ST_FIN_PERM = 3'd6,
    ST_TAG      = 3'd7
  } state_t;

  localparam int ROUND_MAX = 12;

  localparam logic INPUT_MODE_LOAD     = 1'b0;
  localparam logic INPUT_MODE_FEEDBACK = 1'b1;

  // A reduced permutation p^N uses the last N round constants of p^12,
  // so the index runs from ROUND_MAX-N up to ROUND_MAX-1.
  function automatic logic [3:0] round_idx(input logic [3:0] n, input logic [3:0] rc);
    return 4'(ROUND_MAX) - n + rc;
  endfunction

endpackage

// File: rtl/cpt_round_param.sv
// cpt_round_param
//   4-bit round counter with programmable length N.
//   Ports:
//     clock_i  : clock
//     reset_i  : asynchronous active-high reset (rc -> 0)
//     clr_i    : synchronous clear (has priority over en_i)
//     en_i     : advance the counter by one
//     n_i      : permutation length N (2..12)
//     rc_o     : current round count 0..N-1
//     last_o   : rc_o == N-1
module cpt_round_param
  import ascon_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [3:0] n_i,
  output logic [3:0] rc_o,
  output logic       last_o
);

  logic [3:0] rc_q;
  logic [3:0] rc_d;

  always_comb begin
    rc_d = rc_q;
    if (clr_i) begin
      rc_d = 4'd0;
    end else if (en_i) begin
      rc_d = rc_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rc_q <= 4'd0;
    end else begin
      rc_q <= rc_d;
    end
  end

  assign rc_o   = rc_q;
  assign last_o = (rc_q == (n_i - 4'd1));

endmodule

// File: rtl/ascon_phase_ctrl.sv
// ascon_phase_ctrl
//   Control FSM for the full ASCON-128 encryption flow:
//   INIT (p^a) -> AD blocks (p^b each) -> PT blocks (p^b each, last one p^a
//   as finalisation) -> TAG.
//
//   Block handshake: blk_valid_i is a level from the datapath saying a data
//   block is present. In AD_WAIT/PT_WAIT the block is consumed in the same
//   cycle it is valid (blk_ready_o = blk_valid_i) and that cycle is round 0
//   of the following permutation. In every other state blk_valid_i is
//   ignored and blk_ready_o is 0.
//
//   Ports:
//     clock_i, reset_i     : clock, asynchronous active-high reset
//     start_i              : start request (only in IDLE)
//     nb_ad_i, nb_pt_i     : AD / PT block counts, sampled on start
//     blk_valid_i          : data block available
//     blk_ready_o          : data block consumed this cycle
//     round_o              : round-constant index
//     en_reg_state_o       : state register load (every round cycle)
//     input_mode_o         : 0 = load IV||K||N, 1 = feedback
//     xor_data_begin_o     : XOR data block into permutation input
//     xor_key_begin_o      : XOR 0*||K into permutation input
//     xor_key_end_o        : XOR 0*||K into permutation output
//     xor_domain_o         : XOR 1 into LSB of permutation output
//     cipher_valid_o       : ciphertext block valid
//     tag_valid_o, end_o   : tag valid / operation complete
//     busy_o               : FSM not in IDLE
//     dbg_state_o          : current FSM state (observation only)
//
//   ROUNDS_A / ROUNDS_B must lie in 2..12.
module ascon_phase_ctrl
  import ascon_ctrl_pkg::*;
#(
  parameter int ROUNDS_A   = 12,
  parameter int ROUNDS_B   = 6,
  parameter int MAX_BLOCKS = 15,
  localparam int BLK_W     = $clog2(MAX_BLOCKS + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] nb_ad_i,
  input  logic [BLK_W-1:0] nb_pt_i,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  output logic [3:0]       round_o,
  output logic             en_reg_state_o,
  output logic             input_mode_o,
  output logic             xor_data_begin_o,
  output logic             xor_key_begin_o,
  output logic             xor_key_end_o,
  output logic             xor_domain_o,
  output logic             cipher_valid_o,
  output logic             tag_valid_o,
  output logic             end_o,
  output logic             busy_o,
  output state_t           dbg_state_o
);

  localparam logic [3:0]       N_A     = 4'(ROUNDS_A);
  localparam logic [3:0]       N_B     = 4'(ROUNDS_B);
  localparam logic [BLK_W-1:0] BLK_ONE = BLK_W'(1);

  state_t           state_q, state_d;
  logic [BLK_W-1:0] ad_cnt_q, ad_cnt_d;
  logic [BLK_W-1:0] pt_cnt_q, pt_cnt_d;

  logic       rc_clr;
  logic       rc_en;
  logic [3:0] n_sel;
  logic [3:0] rc;
  logic       rc_last;
  logic [3:0] rnd;

  // Length of the permutation the current state belongs to. The last PT
  // block's handshake already starts the finalisation p^a.
  assign n_sel = ((state_q == ST_INIT) || (state_q == ST_FIN_PERM) ||
                  ((state_q == ST_PT_WAIT) && (pt_cnt_q == BLK_ONE))) ? N_A : N_B;

  assign rnd = round_idx(n_sel, rc);

  cpt_round_param u_cpt_round (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clr_i   (rc_clr),
    .en_i    (rc_en),
    .n_i     (n_sel),
    .rc_o    (rc),
    .last_o  (rc_last)
  );

  always_comb begin
    state_d          = state_q;
    ad_cnt_d         = ad_cnt_q;
    pt_cnt_d         = pt_cnt_q;
    rc_clr           = 1'b0;
    rc_en            = 1'b0;
    blk_ready_o      = 1'b0;
    round_o          = 4'd0;
    en_reg_state_o   = 1'b0;
    input_mode_o     = INPUT_MODE_LOAD;
    xor_data_begin_o = 1'b0;
    xor_key_begin_o  = 1'b0;
    xor_key_end_o    = 1'b0;
    xor_domain_o     = 1'b0;
    cipher_valid_o   = 1'b0;
    tag_valid_o      = 1'b0;
    end_o            = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        rc_clr = 1'b1;
        if (start_i) begin
          ad_cnt_d = nb_ad_i;
          // A zero PT count still needs one (empty, padded) block.
          pt_cnt_d = (nb_pt_i == '0) ? BLK_ONE : nb_pt_i;
          state_d  = ST_INIT;
        end
      end

      ST_INIT: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd;
        input_mode_o   = (rc == 4'd0) ? INPUT_MODE_LOAD : INPUT_MODE_FEEDBACK;
        rc_en          = 1'b1;
        if (rc_last) begin
          rc_clr        = 1'b1;
          xor_key_end_o = 1'b1;
          // Without AD the domain separator goes in right after init.
          xor_domain_o  = (ad_cnt_q == '0);
          state_d       = (ad_cnt_q != '0) ? ST_AD_WAIT : ST_PT_WAIT;
        end
      end

      ST_AD_WAIT: begin
        round_o     = rnd;
        blk_ready_o = blk_valid_i;
        if (blk_valid_i) begin
          en_reg_state_o   = 1'b1;
          input_mode_o     = INPUT_MODE_FEEDBACK;
          xor_data_begin_o = 1'b1;
          rc_en            = 1'b1;
          state_d          = ST_AD_PERM;
        end
      end

      ST_AD_PERM: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd;
        input_mode_o   = INPUT_MODE_FEEDBACK;
        rc_en          = 1'b1;
        if (rc_last) begin
          rc_clr   = 1'b1;
          ad_cnt_d = ad_cnt_q - BLK_ONE;
          if (ad_cnt_q == BLK_ONE) begin
            xor_domain_o = 1'b1;
            state_d      = ST_PT_WAIT;
          end else begin
            state_d      = ST_AD_WAIT;
          end
        end
      end

      ST_PT_WAIT: begin
        round_o     = rnd;
        blk_ready_o = blk_valid_i;
        if (blk_valid_i) begin
          en_reg_state_o   = 1'b1;
          input_mode_o     = INPUT_MODE_FEEDBACK;
          xor_data_begin_o = 1'b1;
          cipher_valid_o   = 1'b1;
          rc_en            = 1'b1;
          if (pt_cnt_q == BLK_ONE) begin
            xor_key_begin_o = 1'b1;
            state_d         = ST_FIN_PERM;
          end else begin
            state_d         = ST_PT_PERM;
          end
        end
      end

      ST_PT_PERM: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd;
        input_mode_o   = INPUT_MODE_FEEDBACK;
        rc_en          = 1'b1;
        if (rc_last) begin
          rc_clr   = 1'b1;
          pt_cnt_d = pt_cnt_q - BLK_ONE;
          state_d  = ST_PT_WAIT;
        end
      end

      ST_FIN_PERM: begin
        en_reg_state_o = 1'b1;
        round_o        = rnd;
        input_mode_o   = INPUT_MODE_FEEDBACK;
        rc_en          = 1'b1;
        if (rc_last) begin
          rc_clr        = 1'b1;
          xor_key_end_o = 1'b1;
          state_d       = ST_TAG;
        end
      end

      ST_TAG: begin
        rc_clr      = 1'b1;
        tag_valid_o = 1'b1;
        end_o       = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      ad_cnt_q <= '0;
      pt_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ad_cnt_q <= ad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
    end
  end

  assign busy_o      = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule
